// File: rtl/fir_sched_pkg.sv
// Shared types and helpers for the FIR channel scheduler.
// State encoding, channel-index width helper and one-hot decode.
package fir_sched_pkg;

  // Widest channel count the scheduler supports.
  localparam int MAX_CH = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    DELIVER = 2'd3
  } state_t;

  // Width of a channel index; never below one bit.
  function automatic int ch_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // One-hot decode of a channel index into the widest supported vector.
  function automatic logic [MAX_CH-1:0] onehot(input logic [3:0] idx);
    logic [MAX_CH-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/fir_rr_arbiter.sv
// Round-robin arbiter: rotating priority encoder that searches the
// request vector starting one past the last-served channel.
module fir_rr_arbiter
  import fir_sched_pkg::*;
#(
  parameter  int N_CH = 4,
  localparam int CH_W = ch_w(N_CH)
) (
  input  logic [N_CH-1:0] i_req,
  input  logic [CH_W-1:0] i_rr_ptr,
  output logic [CH_W-1:0] o_grant,
  output logic            o_any_req
);

  logic [CH_W:0]   w_sum;
  logic [CH_W-1:0] w_idx;

  // First asserted request at rr_ptr+1, rr_ptr+2, ... modulo N_CH.
  always_comb begin
    // NOTE: every output gets a default before the search loop so no
    // path through the block leaves a value held, which would infer a latch.
    o_grant   = '0;
    o_any_req = 1'b0;
    w_sum     = '0;
    w_idx     = '0;
    for (int k = 1; k <= N_CH; k++) begin
      w_sum = {1'b0, i_rr_ptr} + (CH_W+1)'(k);
      if (w_sum >= (CH_W+1)'(N_CH)) begin
        w_sum = w_sum - (CH_W+1)'(N_CH);
      end
      w_idx = w_sum[CH_W-1:0];
      if (!o_any_req && i_req[w_idx]) begin
        o_any_req = 1'b1;
        o_grant   = w_idx;
      end
    end
  end

endmodule

// File: rtl/fir_channel_scheduler.sv
// Time-multiplexes one FIR engine among N_CH sample channels.
// Accepts one sample per transaction via round-robin arbitration,
// issues it with its channel index, waits for the engine result and
// returns it to the owning channel.
// Optional build macro FIR_SCHED_WATCHDOG_EN adds a WAIT-state timeout
// (TIMEOUT parameter) with sticky err and err_ch outputs.
module fir_channel_scheduler
  import fir_sched_pkg::*;
#(
  parameter  int N_CH    = 4,
  parameter  int WIDTH   = 16,
`ifdef FIR_SCHED_WATCHDOG_EN
  parameter  int TIMEOUT = 256,
`endif
  localparam int CH_W    = ch_w(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH-1:0]       req_valid,
  input  logic [N_CH*WIDTH-1:0] req_data,
  output logic [N_CH-1:0]       req_ready,
  output logic [WIDTH-1:0]      eng_in,
  output logic                  eng_valid,
  output logic [CH_W-1:0]       eng_ch,
  input  logic [WIDTH-1:0]      eng_out,
  input  logic                  eng_out_valid,
  output logic [WIDTH-1:0]      res_data,
  output logic [N_CH-1:0]       res_valid,
  output logic                  busy
`ifdef FIR_SCHED_WATCHDOG_EN
  ,
  output logic                  err,
  output logic [CH_W-1:0]       err_ch
`endif
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CH_W-1:0]  r_rr_ptr;
  logic [CH_W-1:0]  r_grant;
  logic [WIDTH-1:0] r_sample;
  logic [WIDTH-1:0] r_res_data;

  logic [CH_W-1:0]  w_arb_grant;
  logic             w_any_req;
  logic [N_CH-1:0]  w_arb_oh;
  logic [N_CH-1:0]  w_grant_oh;
  logic             w_accept;
  logic             w_capture;
  logic             w_timeout;
  logic [WIDTH-1:0] w_req_arr [N_CH];

  // Unpack the flat sample bus into one word per channel.
  for (genvar g = 0; g < N_CH; g++) begin : g_unpack
    assign w_req_arr[g] = req_data[g*WIDTH +: WIDTH];
  end

  fir_rr_arbiter #(
    .N_CH (N_CH)
  ) u_arb (
    .i_req     (req_valid),
    .i_rr_ptr  (r_rr_ptr),
    .o_grant   (w_arb_grant),
    .o_any_req (w_any_req)
  );

  assign w_arb_oh   = N_CH'(onehot(4'(w_arb_grant)));
  assign w_grant_oh = N_CH'(onehot(4'(r_grant)));

`ifdef FIR_SCHED_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);

  logic [WD_W-1:0] r_wd_cnt;
  logic            r_err;
  logic [CH_W-1:0] r_err_ch;

  // Watchdog: clear entering WAIT, count WAIT cycles, flag timeouts.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wd_cnt <= '0;
      r_err    <= 1'b0;
      r_err_ch <= '0;
    end else begin
      if (r_state == ISSUE) begin
        r_wd_cnt <= '0;
      end else if (r_state == WAIT) begin
        r_wd_cnt <= r_wd_cnt + 1'b1;
      end
      if (w_timeout) begin
        r_err    <= 1'b1;
        r_err_ch <= r_grant;
      end
    end
  end

  assign w_timeout = (r_state == WAIT) && !eng_out_valid &&
                     (r_wd_cnt == WD_W'(TIMEOUT - 1));
  assign err       = r_err;
  assign err_ch    = r_err_ch;
`else
  assign w_timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic and transaction strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any_req) begin
          w_accept    = 1'b1;
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        w_state_nxt = WAIT;
      end
      WAIT: begin
        if (eng_out_valid) begin
          w_capture   = 1'b1;
          w_state_nxt = DELIVER;
        end else if (w_timeout) begin
          w_state_nxt = DELIVER;
        end
      end
      DELIVER: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Grant/sample latch, result capture and round-robin pointer update.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rr_ptr   <= CH_W'(N_CH - 1);
      r_grant    <= '0;
      r_sample   <= '0;
      r_res_data <= '0;
    end else begin
      if (w_accept) begin
        r_grant  <= w_arb_grant;
        r_sample <= w_req_arr[w_arb_grant];
      end
      if (w_capture) begin
        r_res_data <= eng_out;
      end else if (w_timeout) begin
        r_res_data <= '0;
      end
      if (r_state == DELIVER) begin
        r_rr_ptr <= r_grant;
      end
    end
  end

  assign req_ready = (r_state == IDLE && w_any_req) ? w_arb_oh : '0;
  assign eng_valid = (r_state == ISSUE);
  assign eng_in    = r_sample;
  assign eng_ch    = r_grant;
  assign res_valid = (r_state == DELIVER) ? w_grant_oh : '0;
  assign res_data  = r_res_data;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_fir_channel_scheduler.sv
// Directed testbench for fir_channel_scheduler with a fixed-latency
// FIR engine model. Watchdog checks are built when
// FIR_SCHED_WATCHDOG_EN is defined.
module tb_fir_channel_scheduler;

  localparam int N_CH  = 4;
  localparam int WIDTH = 16;
  localparam int L     = 5;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [N_CH-1:0]       req_valid;
  logic [N_CH*WIDTH-1:0] req_data;
  logic [N_CH-1:0]       req_ready;
  logic [WIDTH-1:0]      eng_in;
  logic                  eng_valid;
  logic [1:0]            eng_ch;
  logic [WIDTH-1:0]      eng_out;
  logic                  eng_out_valid;
  logic [WIDTH-1:0]      res_data;
  logic [N_CH-1:0]       res_valid;
  logic                  busy;
`ifdef FIR_SCHED_WATCHDOG_EN
  logic                  err;
  logic [1:0]            err_ch;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  // Engine model controls.
  logic             eng_en;
  logic             man_valid;
  logic [WIDTH-1:0] m_data = '0;
  int               m_cnt  = 0;

  always #5 clk = ~clk;

  fir_channel_scheduler #(
    .N_CH    (N_CH),
    .WIDTH   (WIDTH)
`ifdef FIR_SCHED_WATCHDOG_EN
    ,
    .TIMEOUT (16)
`endif
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .eng_in        (eng_in),
    .eng_valid     (eng_valid),
    .eng_ch        (eng_ch),
    .eng_out       (eng_out),
    .eng_out_valid (eng_out_valid),
    .res_data      (res_data),
    .res_valid     (res_valid),
    .busy          (busy)
`ifdef FIR_SCHED_WATCHDOG_EN
    ,
    .err           (err),
    .err_ch        (err_ch)
`endif
  );

  // Engine transfer function: 3*x + channel.
  function automatic logic [WIDTH-1:0] f(input logic [WIDTH-1:0] x, input int ch);
    return x * 16'd3 + 16'(ch);
  endfunction

  // Engine model: result strobe L cycles after the issue cycle.
  always @(posedge clk) begin
    if (!rst) begin
      m_cnt <= 0;
    end else if (eng_valid && eng_en) begin
      m_cnt  <= L;
      m_data <= f(eng_in, int'(eng_ch));
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
    end
  end

  assign eng_out_valid = (m_cnt == 1) || man_valid;
  assign eng_out       = m_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst       = 1'b0;
    req_valid = '0;
    next_cycle();
    next_cycle();
    rst = 1'b1;
  endtask

  // One full transaction from the current IDLE cycle back to IDLE.
  task automatic txn(input int ch, input logic [WIDTH-1:0] smp, input bit scramble,
                     input bit pulse, input int exp_lat, input logic [WIDTH-1:0] exp_res);
    int k;
    #1;
    check("accept_ready", 32'(req_ready), 32'(1 << ch));
    next_cycle();
    if (scramble) req_data[ch*WIDTH +: WIDTH] = ~smp;
    check("issue_valid", 32'(eng_valid), 32'd1);
    check("issue_ch", 32'(eng_ch), 32'(ch));
    check("issue_data", 32'(eng_in), 32'(smp));
    check("issue_ready", 32'(req_ready), 32'd0);
    if (pulse) man_valid = 1'b1;
    k = 0;
    do begin
      next_cycle();
      man_valid = 1'b0;
      k++;
    end while (res_valid == '0 && k < 40);
    check("latency", 32'(k), 32'(exp_lat));
    check("res_valid", 32'(res_valid), 32'(1 << ch));
    check("res_data", 32'(res_data), 32'(exp_res));
    next_cycle();
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_res_valid", 32'(res_valid), 32'd0);
    check("res_hold", 32'(res_data), 32'(exp_res));
  endtask

  logic [WIDTH-1:0] smp [N_CH];

  initial begin
    rst       = 1'b0;
    req_valid = '0;
    req_data  = '0;
    eng_en    = 1'b1;
    man_valid = 1'b0;
    smp[0] = 16'h1000;
    smp[1] = 16'h2001;
    smp[2] = 16'h3002;
    smp[3] = 16'h4003;

    // Reset values.
    do_reset();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_eng_valid", 32'(eng_valid), 32'd0);
    check("rst_eng_in", 32'(eng_in), 32'd0);
    check("rst_eng_ch", 32'(eng_ch), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_data", 32'(res_data), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
`ifdef FIR_SCHED_WATCHDOG_EN
    check("rst_err", 32'(err), 32'd0);
    check("rst_err_ch", 32'(err_ch), 32'd0);
`endif

    // Single request on ch2; data changed after accept must not matter.
    req_data[2*WIDTH +: WIDTH] = 16'h1234;
    req_valid = 4'b0100;
    txn(2, 16'h1234, 1'b1, 1'b0, L + 1, 16'h369E);

    // All channels requesting: order 0,1,2,3,0 after reset.
    do_reset();
    for (int i = 0; i < N_CH; i++) req_data[i*WIDTH +: WIDTH] = smp[i];
    req_valid = 4'b1111;
    txn(0, smp[0], 1'b0, 1'b0, L + 1, f(smp[0], 0));
    txn(1, smp[1], 1'b0, 1'b0, L + 1, f(smp[1], 1));
    txn(2, smp[2], 1'b0, 1'b0, L + 1, f(smp[2], 2));
    txn(3, smp[3], 1'b0, 1'b0, L + 1, f(smp[3], 3));
    txn(0, smp[0], 1'b0, 1'b0, L + 1, f(smp[0], 0));

    // Channels 1 and 3 only: alternate 1,3,1,3.
    req_valid = 4'b1010;
    txn(1, smp[1], 1'b0, 1'b0, L + 1, f(smp[1], 1));
    txn(3, smp[3], 1'b0, 1'b0, L + 1, f(smp[3], 3));
    txn(1, smp[1], 1'b0, 1'b0, L + 1, f(smp[1], 1));
    txn(3, smp[3], 1'b0, 1'b0, L + 1, f(smp[3], 3));

    // Reset during WAIT abandons the transaction; ch0 wins next.
    req_valid = 4'b1111;
    #1;
    check("wr_ready", 32'(req_ready), 32'b0001);
    next_cycle();
    next_cycle();
    next_cycle();
    check("wr_in_wait", 32'(busy), 32'd1);
    rst = 1'b0;
    next_cycle();
    rst = 1'b1;
    #1;
    check("wr_busy", 32'(busy), 32'd0);
    check("wr_res_valid", 32'(res_valid), 32'd0);
    txn(0, smp[0], 1'b0, 1'b0, L + 1, f(smp[0], 0));

    // Stray engine strobes in IDLE and ISSUE are ignored.
    req_valid = '0;
    man_valid = 1'b1;
    next_cycle();
    man_valid = 1'b0;
    check("stray_idle_busy", 32'(busy), 32'd0);
    check("stray_idle_res", 32'(res_valid), 32'd0);
    req_valid = 4'b0010;
    txn(1, smp[1], 1'b0, 1'b1, L + 1, f(smp[1], 1));

`ifdef FIR_SCHED_WATCHDOG_EN
    // Engine silent: timeout after 16 WAIT cycles with zero result.
    do_reset();
    eng_en    = 1'b0;
    req_valid = 4'b0100;
    txn(2, smp[2], 1'b0, 1'b0, 17, 16'h0000);
    check("wd_err", 32'(err), 32'd1);
    check("wd_err_ch", 32'(err_ch), 32'd2);
    eng_en    = 1'b1;
    req_valid = 4'b1000;
    txn(3, smp[3], 1'b0, 1'b0, L + 1, f(smp[3], 3));
    check("wd_err_sticky", 32'(err), 32'd1);
    check("wd_err_ch_hold", 32'(err_ch), 32'd2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_channel_scheduler.md
Name: fir_channel_scheduler

Overview:
Time-multiplexes one shared FIR engine (datapath plus its controller) among N_CH independent sample channels. Each channel presents samples over a valid/ready handshake. A round-robin arbiter picks one channel, issues its sample to the engine with a channel index so the engine can select that channel's delay-line/coefficient bank, then waits for the engine result and returns it to the owning channel. Sits between the channel front-ends and the FIR engine top.

Parameters:
N_CH, 4, number of requesting channels (2..16)
WIDTH, 16, sample and result width in bits
TIMEOUT, 256, WAIT-state cycle limit; used only with the optional feature

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-low reset
req_valid  in  N_CH  per-channel sample valid
req_data  in  N_CH*WIDTH  packed samples; channel i occupies bits [i*WIDTH +: WIDTH]
req_ready  out  N_CH  one-hot accept, combinational
eng_in  out  WIDTH  sample to engine
eng_valid  out  1  one-cycle issue strobe to engine
eng_ch  out  $clog2(N_CH)  channel index for engine bank select
eng_out  in  WIDTH  engine result
eng_out_valid  in  1  engine result strobe
res_data  out  WIDTH  result to channels (shared bus)
res_valid  out  N_CH  one-hot result strobe, one cycle
busy  out  1  high in every state except IDLE

Behaviour:
- Reset: rst==0 sampled at a clk edge -> state IDLE, rr_ptr=N_CH-1 (so channel 0 wins first), grant latch 0, eng_valid=0, eng_in=0, eng_ch=0, res_valid=0, res_data=0. Reset mid-operation abandons the transaction; no res_valid for it.
- FSM states: IDLE, ISSUE, WAIT, DELIVER.
- IDLE: grant = first asserted req_valid searching rr_ptr+1, rr_ptr+2, ..., wrapping modulo N_CH. req_ready = onehot(grant) only in IDLE and only when some req_valid is high; it is 0 in every other state. A transfer occurs when req_valid[i] and req_ready[i] are both high. On transfer, latch req_data[grant] and grant, then go to ISSUE. With no request, stay in IDLE.
- ISSUE (1 cycle): eng_valid=1, eng_in=latched sample, eng_ch=grant. Go to WAIT.
- WAIT: hold eng_ch. When eng_out_valid=1, capture eng_out into res_data and go to DELIVER.
- DELIVER (1 cycle): res_valid=onehot(grant), res_data stable. rr_ptr<=grant. Go to IDLE.
- Latency: accept at cycle T; ISSUE at T+1; if eng_out_valid arrives at T+1+L (L>=1), res_valid is at T+2+L. Minimum accept-to-accept spacing is L+3 cycles.
- eng_out_valid outside WAIT (including in the same cycle as ISSUE) is ignored.
- res_data holds its last value after DELIVER until the next capture.
- A channel that drops req_valid before it is granted loses nothing. Granted data is already latched, so later changes to req_data have no effect.
- Fairness: with all channels continuously requesting, the grant order is 0,1,...,N_CH-1,0,...

Optional Feature:
FIR_SCHED_WATCHDOG_EN.
- Defined: a counter clears on entry to WAIT and increments each WAIT cycle. When it reaches TIMEOUT with no eng_out_valid, force res_data=0 and go to DELIVER as normal. Extra outputs: err (sticky, cleared only by reset) and err_ch ($clog2(N_CH), channel of the most recent timeout).
- Undefined: WAIT waits indefinitely. err, err_ch, the counter and the TIMEOUT logic do not exist.

Decomposition:
- Package fir_sched_pkg: state enum typedef (IDLE, ISSUE, WAIT, DELIVER), CH_W = $clog2(N_CH) helper function, onehot-from-index function.
- Sub-module fir_rr_arbiter: combinational rotate-priority-encode of req_valid from rr_ptr+1, returning grant index and any_req. The scheduler instantiates it once.

Test Plan:
- Single request, N_CH=4, engine model L=5: req_valid[2]=1 with data 0x1234 at T. Expect req_ready=4'b0100 at T; eng_valid/eng_ch=2/eng_in=0x1234 at T+1; res_valid=4'b0100 with res_data equal to the model output at T+7.
- All four channels valid continuously after reset -> grant order 0,1,2,3,0; each res_valid matches its channel's sample routed through the model.
- Channels 1 and 3 requesting continuously, others idle -> grants alternate 1,3,1,3; req_ready never asserts for 0 or 2.
- rst=0 for one cycle during WAIT -> no res_valid for that transaction; busy=0 the next cycle; next grant with all channels requesting is ch0.
- eng_out_valid pulsed in IDLE and in ISSUE -> ignored; no res_valid; state sequence unchanged.
- With FIR_SCHED_WATCHDOG_EN and TIMEOUT=16, engine never responds -> res_valid for the granted channel after 16 WAIT cycles with res_data=0; err=1 stays set across later good transactions; err_ch = that channel.
